// File: rtl/progmem_pkg.sv
// ---------------------------------------------------------------------------
// progmem_pkg
// Shared types and sizes for the program memory / boot loader.
//   state_t : loader FSM encoding (CLEAR=0, LOAD=1, RUN=2; 3 is unused)
//   ADDR_W  : processor address width
//   DATA_W  : byte width of the store and of the load stream
//   DEPTH   : store depth, 2**ADDR_W
// Optional feature macro used by the including design: PROGMEM_CLEAR_EN
// ---------------------------------------------------------------------------
package progmem_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_t;

endpackage : progmem_pkg

// File: rtl/prog_ram.sv
// ---------------------------------------------------------------------------
// prog_ram
// DEPTH x DATA_W instruction store. Synchronous write port and an
// asynchronous (combinational) read port, so the processor sees the byte for
// its address in the same cycle. Contents are never reset.
// Ports:
//   clk     : clock, write on rising edge
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data (combinational)
// ---------------------------------------------------------------------------
module prog_ram
    import progmem_pkg::*;
#(
    parameter int P_ADDR_W = ADDR_W,
    parameter int P_DATA_W = DATA_W,
    parameter int P_DEPTH  = DEPTH
) (
    input  logic                clk,
    input  logic                i_we,
    input  logic [P_ADDR_W-1:0] i_waddr,
    input  logic [P_DATA_W-1:0] i_wdata,
    input  logic [P_ADDR_W-1:0] i_raddr,
    output logic [P_DATA_W-1:0] o_rdata
);

    logic [P_DATA_W-1:0] r_mem [P_DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : prog_ram

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
// Program memory and boot loader in front of the processor. A program
// arrives as a valid/ready byte stream and is written into a 256x8 store;
// the processor is then released from reset and fetches bytes from the
// store. A reload request in RUN re-enters the load sequence with the
// processor held in reset.
//
// Optional feature macro: PROGMEM_CLEAR_EN
//   defined   : reset and reload pass through a 256-cycle CLEAR state that
//               zeroes the store before LOAD.
//   undefined : no CLEAR state; unloaded locations keep old contents.
//
// Ports:
//   clk        : clock
//   CLB        : asynchronous active-low reset
//   load_valid : stream byte available
//   load_data  : stream byte
//   load_last  : final byte of program (meaningful on a transfer)
//   load_ready : loader accepts a byte this cycle (LOAD state)
//   reload_req : restart the load (sampled in RUN only)
//   Address    : processor fetch address
//   Data       : fetched byte (00 outside RUN)
//   cpu_rst_n  : active-low reset to processor (high only in RUN)
//   load_count : bytes accepted in current/most recent load
//   ovf_err    : sticky, store filled before load_last was seen
// ---------------------------------------------------------------------------
module prog_loader
    import progmem_pkg::*;
(
    input  logic              clk,
    input  logic              CLB,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              reload_req,
    input  logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] Data,
    output logic              cpu_rst_n,
    output logic [ADDR_W:0]   load_count,
    output logic              ovf_err
);

`ifdef PROGMEM_CLEAR_EN
    localparam state_t START_STATE = CLEAR;
`else
    localparam state_t START_STATE = LOAD;
`endif

    state_t              r_state;
    state_t              r_state_next;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W:0]     r_load_count;
    logic                r_ovf_err;
`ifdef PROGMEM_CLEAR_EN
    logic [ADDR_W-1:0]   r_clr_ptr;
`endif

    logic                w_xfer;
    logic                w_reload;
    logic                w_we;
    logic [ADDR_W-1:0]   w_waddr;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W-1:0]   w_rdata;

    assign w_xfer   = load_valid && (r_state == LOAD);
    assign w_reload = reload_req && (r_state == RUN);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            r_state <= START_STATE;
        end else begin
            r_state <= r_state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        r_state_next = r_state;
        case (r_state)
`ifdef PROGMEM_CLEAR_EN
            CLEAR: begin
                if (r_clr_ptr == '1) r_state_next = LOAD;
            end
`endif
            LOAD: begin
                // Either the program ends, or the last location was just
                // filled (overflow); both hand over to the processor.
                if (w_xfer && (load_last || (r_wr_ptr == '1))) r_state_next = RUN;
            end
            RUN: begin
                if (reload_req) r_state_next = START_STATE;
            end
            default: r_state_next = START_STATE;
        endcase
    end

    // ---------------- outputs, decoded from the state register ----------------
    always_comb begin
        load_ready = (r_state == LOAD);
        cpu_rst_n  = (r_state == RUN);
        Data       = (r_state == RUN) ? w_rdata : '0;
    end

    assign load_count = r_load_count;
    assign ovf_err    = r_ovf_err;

    // ---------------- pointers and flags ----------------
    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            r_wr_ptr     <= '0;
            r_load_count <= '0;
            r_ovf_err    <= 1'b0;
        end else if (w_reload) begin
            r_wr_ptr     <= '0;
            r_load_count <= '0;
            r_ovf_err    <= 1'b0;
        end else if (w_xfer) begin
            r_wr_ptr     <= r_wr_ptr + 1'b1;
            r_load_count <= r_load_count + 1'b1;
            if ((r_wr_ptr == '1) && !load_last) r_ovf_err <= 1'b1;
        end
    end

`ifdef PROGMEM_CLEAR_EN
    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            r_clr_ptr <= '0;
        end else if (w_reload) begin
            r_clr_ptr <= '0;
        end else if (r_state == CLEAR) begin
            r_clr_ptr <= r_clr_ptr + 1'b1;
        end
    end

    // CLEAR owns the write port; stream bytes are not accepted then.
    assign w_we    = w_xfer || (r_state == CLEAR);
    assign w_waddr = (r_state == CLEAR) ? r_clr_ptr : r_wr_ptr;
    assign w_wdata = (r_state == CLEAR) ? '0 : load_data;
`else
    assign w_we    = w_xfer;
    assign w_waddr = r_wr_ptr;
    assign w_wdata = load_data;
`endif

    prog_ram #(
        .P_ADDR_W (ADDR_W),
        .P_DATA_W (DATA_W),
        .P_DEPTH  (DEPTH)
    ) u_prog_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (Address),
        .o_rdata (w_rdata)
    );

endmodule : prog_loader

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
// Directed self-checking bench for prog_loader. Works with and without
// PROGMEM_CLEAR_EN. Inputs change and outputs are sampled 1 ns after the
// rising edge.
// ---------------------------------------------------------------------------
module tb_prog_loader;
    import progmem_pkg::*;

    logic              clk = 1'b0;
    logic              CLB;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              reload_req;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] Data;
    logic              cpu_rst_n;
    logic [ADDR_W:0]   load_count;
    logic              ovf_err;

    int tests = 0;
    int fails = 0;

`ifdef PROGMEM_CLEAR_EN
    localparam logic READY_AT_RESET = 1'b0;
    localparam bit   CLEAR_EN       = 1'b1;
`else
    localparam logic READY_AT_RESET = 1'b1;
    localparam bit   CLEAR_EN       = 1'b0;
`endif

    prog_loader dut (
        .clk        (clk),
        .CLB        (CLB),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .reload_req (reload_req),
        .Address    (Address),
        .Data       (Data),
        .cpu_rst_n  (cpu_rst_n),
        .load_count (load_count),
        .ovf_err    (ovf_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
        $display("[TB] %-16s obs=%0h exp=%0h", tag, obs, exp);
    endtask

    // One transfer: valid held for one edge while ready.
    task automatic send(input logic [7:0] b, input logic last);
        load_valid = 1'b1;
        load_data  = b;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!load_ready && n < 400) begin
            tick();
            n++;
        end
        check(tag, {15'd0, load_ready}, 16'd1);
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
        Address = a;
        #1;
        check(tag, {8'd0, Data}, {8'd0, exp});
    endtask

    task automatic reload();
        reload_req = 1'b1;
        tick();
        reload_req = 1'b0;
    endtask

    logic [7:0] exp_b;

    initial begin
        CLB        = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;
        load_last  = 1'b0;
        reload_req = 1'b0;
        Address    = 8'h00;
        #12;
        // ---- reset values ----
        check("rst_ready",  {15'd0, load_ready}, {15'd0, READY_AT_RESET});
        check("rst_cpurst", {15'd0, cpu_rst_n},  16'd0);
        check("rst_count",  {7'd0, load_count},  16'd0);
        check("rst_ovf",    {15'd0, ovf_err},    16'd0);
        check("rst_data",   {8'd0, Data},        16'd0);

        // Hold first byte valid across reset release: not consumed in CLEAR.
        @(posedge clk);
        #1;
        load_valid = 1'b1;
        load_data  = 8'hA9;
        load_last  = 1'b0;
        CLB        = 1'b1;
        if (CLEAR_EN) begin
            for (int i = 0; i < 256; i++) begin
                if (load_ready !== 1'b0 || load_count !== 9'd0 || cpu_rst_n !== 1'b0) begin
                    check("clear_hold", {6'd0, load_ready, load_count}, 16'd0);
                end
                tick();
            end
            tests++;
            check("clear_end_rdy", {15'd0, load_ready}, 16'd1);
            check("clear_end_cnt", {7'd0, load_count}, 16'd0);
        end else begin
            check("first_rdy", {15'd0, load_ready}, 16'd1);
        end
        tick();                                 // A9 -> addr 00
        load_valid = 1'b0;
        check("cnt_after_a9", {7'd0, load_count}, 16'd1);
        tick();                                 // idle cycle, nothing written
        check("cnt_idle", {7'd0, load_count}, 16'd1);
        send(8'h3F, 1'b0);
        check("cpurst_in_load", {15'd0, cpu_rst_n}, 16'd0);
        rd("data_in_load", 8'h00, 8'h00);
        send(8'hC0, 1'b1);
        check("cnt_3", {7'd0, load_count}, 16'd3);
        check("run_cpurst", {15'd0, cpu_rst_n}, 16'd1);
        check("run_ready", {15'd0, load_ready}, 16'd0);
        check("run_ovf", {15'd0, ovf_err}, 16'd0);
        rd("rd_00", 8'h00, 8'hA9);
        rd("rd_01", 8'h01, 8'h3F);
        rd("rd_02", 8'h02, 8'hC0);

        // ---- overflow: 256 bytes without load_last ----
        reload();
        check("rl1_cpurst", {15'd0, cpu_rst_n}, 16'd0);
        check("rl1_count", {7'd0, load_count}, 16'd0);
        wait_ready("rl1_ready");
        for (int i = 0; i < 256; i++) begin
            if (cpu_rst_n !== 1'b0) check("ovf_early_run", {15'd0, cpu_rst_n}, 16'd0);
            send(8'(i), 1'b0);
        end
        check("ovf_flag", {15'd0, ovf_err}, 16'd1);
        check("ovf_count", {7'd0, load_count}, 16'd256);
        check("ovf_cpurst", {15'd0, cpu_rst_n}, 16'd1);
        rd("ovf_rd_ff", 8'hFF, 8'hFF);
        rd("ovf_rd_01", 8'h01, 8'h01);
        rd("ovf_rd_80", 8'h80, 8'h80);

        // ---- reload and single-byte load ----
        reload();
        check("rl2_cpurst", {15'd0, cpu_rst_n}, 16'd0);
        check("rl2_ovf", {15'd0, ovf_err}, 16'd0);
        check("rl2_count", {7'd0, load_count}, 16'd0);
        wait_ready("rl2_ready");
        send(8'h5A, 1'b1);
        check("one_count", {7'd0, load_count}, 16'd1);
        check("one_cpurst", {15'd0, cpu_rst_n}, 16'd1);
        rd("one_rd_00", 8'h00, 8'h5A);
        exp_b = CLEAR_EN ? 8'h00 : 8'h01;
        rd("one_rd_01", 8'h01, exp_b);

        // ---- async reset mid-load ----
        reload();
        wait_ready("rl3_ready");
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        check("pre_abort_cnt", {7'd0, load_count}, 16'd2);
        #2;
        CLB = 1'b0;                             // well before next edge
        #1;
        check("abort_count", {7'd0, load_count}, 16'd0);
        check("abort_ready", {15'd0, load_ready}, {15'd0, READY_AT_RESET});
        check("abort_cpurst", {15'd0, cpu_rst_n}, 16'd0);
        check("abort_data", {8'd0, Data}, 16'd0);
        tick();
        CLB = 1'b1;
        wait_ready("rst2_ready");
        send(8'h33, 1'b1);
        check("restart_count", {7'd0, load_count}, 16'd1);
        rd("restart_rd_00", 8'h00, 8'h33);
        exp_b = CLEAR_EN ? 8'h00 : 8'h22;
        rd("restart_rd_01", 8'h01, exp_b);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_prog_loader

// File: doc/prog_loader.md
# prog_loader

Program memory and boot loader that sits directly upstream of the processor. It accepts a program as a valid/ready byte stream, writes it into a 256x8 instruction store, then releases the processor from reset. From then on it serves instruction/operand bytes on `Data` for the processor's `Address`. A reload request re-enters the load sequence with the processor held in reset.

## Interface
Parameters:
- `ADDR_W`, 8: address width; fixed to match the processor address bus.
- `DATA_W`, 8: byte width of the store and load stream.
- `DEPTH`, 256: store depth, equal to 2^`ADDR_W`.

Ports:
- `clk` in 1: the single clock; all state changes on the rising edge.
- `CLB` in 1: reset, asynchronous and active-low.
- `load_valid` in 1: the upstream stream has a byte.
- `load_data` in 8: the stream byte.
- `load_last` in 1: qualifies the final byte of the program.
- `load_ready` out 1: the loader accepts a byte this cycle.
- `reload_req` in 1: request to restart the load; sampled only in RUN.
- `Address` in 8: fetch address from the processor.
- `Data` out 8: fetched byte to the processor.
- `cpu_rst_n` out 1: active-low reset driven into the processor `rst`.
- `load_count` out 9: number of bytes accepted in the current or most recent load.
- `ovf_err` out 1: sticky flag, set when the store filled before `load_last` was seen.

## Operation
- States: CLEAR, LOAD, RUN.
- State after reset: CLEAR when `PROGMEM_CLEAR_EN` is defined, LOAD otherwise.
- Reset values:
  - `load_ready`=0 with the macro, 1 without it.
  - `cpu_rst_n`=0, `load_count`=0, `ovf_err`=0.
  - `Data`=8'h00.
  - Write and clear pointers=0.
- Store contents are not reset.
- CLEAR:
  - Writes 8'h00 to location `clr_ptr` each cycle and increments `clr_ptr`.
  - After writing location 255, moves to LOAD; CLEAR lasts exactly 256 cycles.
  - `load_ready`=0.
- LOAD:
  - `load_ready`=1.
  - A transfer occurs on an edge where `load_valid` and `load_ready` are both 1. It writes `load_data` to `wr_ptr`, increments `wr_ptr` and increments `load_count`.
  - When `load_valid` is low, nothing is written.
  - A transfer with `load_last`=1 moves to RUN.
  - A transfer into location 255 with `load_last`=0 also moves to RUN, sets `ovf_err` and leaves `load_count`=256.
- RUN:
  - `cpu_rst_n`=1 and `load_ready`=0.
  - `Data`=store[`Address`], combinational read.
  - `reload_req`=1 on an edge moves to CLEAR (macro) or LOAD (no macro). On that same edge it zeroes `load_count`, `wr_ptr`, `clr_ptr` and `ovf_err`.
- In CLEAR and LOAD, `Data`=8'h00 and `cpu_rst_n`=0.
- `reload_req` is ignored in CLEAR and LOAD.
- `load_valid` while `load_ready`=0 is not consumed; upstream holds the byte.
- A load of zero bytes is impossible; `load_last` is meaningful only on a transfer.

## Timing
- `cpu_rst_n` and `load_ready` decode directly from the state register, so they are glitch-free.
- `cpu_rst_n` rises in the cycle after the final transfer edge.
- `cpu_rst_n` falls in the cycle after the `reload_req` edge.
- Write latency is 1 edge. A byte written on edge N is readable in RUN from edge N+1.
- Read latency is 0 (combinational), matching the processor's same-cycle `Data` sampling.
- `CLB` low aborts any state immediately with no clock required. Partial load contents remain in the store unless CLEAR runs afterwards.
- Simultaneous final transfer and `reload_req` cannot occur, because the two are sampled in disjoint states.

## Configuration
- `PROGMEM_CLEAR_EN` defined:
  - Reset and reload pass through CLEAR (256 cycles).
  - Unloaded locations read 8'h00.
- `PROGMEM_CLEAR_EN` undefined:
  - There is no CLEAR state; the loader enters LOAD directly.
  - Unloaded locations keep their previous contents (undefined after power-up).
  - The CLEAR encoding is unused.

## Structure
- Package `progmem_pkg` holds:
  - the state enum: CLEAR=2'd0, LOAD=2'd1, RUN=2'd2;
  - `ADDR_W`, `DATA_W` and `DEPTH`.
- Sub-module `prog_ram`: 256x8 array, synchronous write port, asynchronous read port. It is instantiated once.
- The FSM, pointers and flags live in `prog_loader`.

## Test plan
- Reset release with the macro: `load_ready`=0 for 256 cycles, then 1, with `cpu_rst_n`=0 throughout. Without the macro: `load_ready`=1 on the first cycle after reset.
- Load A9,3F,C0 with `load_last` on C0: `load_count`=3 and `cpu_rst_n`=1 the next cycle. `Address`=01 gives `Data`=3F.
- Hold `load_valid`=1 during CLEAR: no write occurs and `load_count` stays 0 until LOAD. The first LOAD transfer goes to address 00.
- Stream 256 bytes (value = index) without `load_last`: RUN after the 256th byte, `ovf_err`=1, `load_count`=256. `Address`=FF gives `Data`=FF.
- In RUN, pulse `reload_req`, then load 1 byte 5A: `cpu_rst_n`=0 the next cycle and `ovf_err` is cleared. Afterwards `Address`=01 reads 00 with the macro, or the old byte without it.
- Drop `CLB` asynchronously after 2 transfers: outputs reach their reset values before the next clock edge, and the load restarts from address 00.
